motor_ramp_ctrl: RTL
====================

# motor_ramp_ctrl

Slew-rate-limited speed sequencer for one motor channel. It accepts signed speed commands over a valid/ready handshake and ramps the PWM generator's duty word toward the target in fixed steps. On direction reversal it decelerates to zero duty, holds a dead/brake interval, flips the direction, then accelerates. It sits between the wall-follower PID output stage and one PWM generator plus its H-bridge direction pin.

## Interface
- `R`, default 10: PWM resolution; duty spans 0..2^R.
- `STEP`, default 8: duty LSBs added or removed per ramp tick; 1 ≤ STEP ≤ 2^R.
- `DEAD_TICKS`, default 4: ramp ticks spent in DEAD before the direction flip; ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run permission; low = stop.
- `ramp_dvsr`  in  32  ramp prescaler; one tick every ramp_dvsr+1 clocks.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on a clock where valid && ready.
- `cmd_speed`  in  R+2  signed two's-complement speed; sign = direction (1 = reverse).
- `duty`  out  R+1  duty word to the PWM generator, registered.
- `dir`  out  1  H-bridge direction, registered.
- `brake`  out  1  high only in DEAD.
- `busy`  out  1  state ≠ IDLE.
- `at_target`  out  1  duty == tgt_mag && dir == tgt_dir.

## Operation
- **Reset values:** duty=0, dir=0, brake=0, state=IDLE, tgt_mag=0, tgt_dir=0, prescaler q=0, dead counter=0.
- **Prescaler:** q_next = (q ≥ ramp_dvsr) ? 0 : q+1; tick = (q == 0). Free-running whenever out of reset. ramp_dvsr=0 gives a tick every clock.
- **Command decode:** mag = |cmd_speed| computed in R+2 bits, saturated to 2^R (covers the most-negative value). tgt_dir = sign bit, except mag == 0, which keeps the current tgt_dir.
- **Acceptance:** cmd_ready = enable && state ≠ DEAD. An accepted command overwrites tgt_mag/tgt_dir immediately; there is no queue.
- **IDLE:** duty == tgt_mag && dir == tgt_dir. Go to RAMP on any mismatch.
- **RAMP:** effective target eff = (tgt_dir == dir) ? tgt_mag : 0. On each tick:
  - duty < eff: duty = min(duty+STEP, eff).
  - duty > eff: duty = max(duty−STEP, eff), computed without underflow.
  - duty == 0 && dir ≠ tgt_dir: go to DEAD, load DEAD_TICKS into the counter.
  - duty == tgt_mag && dir == tgt_dir: go to IDLE.
- **DEAD:** brake=1 and duty held at 0. The counter decrements each tick. On the tick where it reaches 0: dir ← tgt_dir, brake ← 0, go to RAMP.
- **Stop:** enable low forces duty to 0 on the next clock, clears tgt_mag to 0 and sets state to IDLE. dir is retained. When enable returns, the next command starts from duty 0.

## Timing
- The command takes effect on the acceptance edge. The first duty change occurs on the first tick after acceptance. at_target deasserts the cycle after a differing command is accepted.
- A command accepted on a tick edge does not move duty on that same edge.
- A reversal from duty D takes ceil(D/STEP) ticks down, DEAD_TICKS ticks of brake, then ceil(M/STEP) ticks up.
- A command plus enable-low in the same clock: enable wins and the command is dropped; cmd_ready is already 0.
- Changing ramp_dvsr mid-run: q ≥ ramp_dvsr wraps q to 0 on the next clock.
- Asynchronous reset in any state returns all outputs to their reset values immediately.

## Configuration
- Macro: `MOTOR_RAMP_SOFT_STOP_EN`.
- **Defined:** enable low clears tgt_mag and keeps the state machine running. duty ramps to 0 at STEP per tick. cmd_ready stays low. A pending DEAD completes. busy stays high until duty == 0.
- **Undefined:** immediate-stop behaviour as described in Operation.

## Test plan
All scenarios use R=10, STEP=8, DEAD_TICKS=4, ramp_dvsr=0.
- Reset release, enable=1, cmd +100 → duty 8,16,…,96,100 on successive clocks (13 ticks), dir=0; then at_target=1, busy=0.
- At +100, cmd −40 → duty 92…4,0 (13 ticks); brake=1 for 4 ticks with duty=0; dir=1; duty 8…40 (5 ticks); at_target=1.
- cmd +2000 and cmd −2048 → tgt_mag saturates to 1024; duty reaches 1024 after 128 ticks and never exceeds it.
- cmd +300, drop enable at duty=80 → duty=0 next clock, cmd_ready=0. With the macro defined: 72,64,…,0.
- Reversal in DEAD → cmd_ready=0, cmd_valid held until DEAD exits then accepted. A mid-RAMP cmd +50 at duty=120 ramps straight down to 50.
- Assert reset mid-DEAD → duty=0, dir=0, brake=0, busy=0 immediately.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// Slew-rate-limited speed sequencer: ramps the PWM duty toward a signed speed target,
// braking through zero on reversal. Define MOTOR_RAMP_SOFT_STOP_EN to ramp down on disable.
module motor_ramp_ctrl #(
  parameter int R          = 10,
  parameter int STEP       = 8,
  parameter int DEAD_TICKS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [31:0]   ramp_dvsr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [R+1:0]  cmd_speed,
  output logic [R:0]    duty,
  output logic          dir,
  output logic          brake,
  output logic          busy,
  output logic          at_target
);

  localparam int         CW     = $clog2(DEAD_TICKS + 1);
  localparam logic [R:0] FULL   = {1'b1, {R{1'b0}}};
  localparam logic [R:0] STEP_V = (R+1)'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, DEAD} state_t;

  state_t        state, state_n;
  logic [31:0]   q;
  logic          tick, accept, adv, run;
  logic [R+1:0]  abs_spd;
  logic [R:0]    mag, tgt_mag, tgt_mag_n, tmag, eff, stepped, duty_n;
  logic          cmd_dir, tgt_dir, tgt_dir_n, dir_n, brake_n, mismatch;
  logic [CW-1:0] cnt, cnt_n;

  // Free-running ramp prescaler; shrinking ramp_dvsr below q wraps on the next clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= (q >= ramp_dvsr) ? '0 : q + 32'd1;
  end
  assign tick = (q == '0);

  // |speed| saturates at full scale, which also absorbs the most-negative code.
  assign abs_spd = cmd_speed[R+1] ? (~cmd_speed + 1'b1) : cmd_speed;
  assign mag     = (abs_spd > (R+2)'(FULL)) ? FULL : abs_spd[R:0];
  assign cmd_dir = (mag == '0) ? tgt_dir : cmd_speed[R+1];

  assign cmd_ready = enable && (state != DEAD);
  assign accept    = cmd_valid && cmd_ready;
  // A freshly accepted command never moves duty on its own acceptance edge.
  assign adv       = tick && !accept;

`ifdef MOTOR_RAMP_SOFT_STOP_EN
  assign run = 1'b1;
`else
  assign run = enable;
`endif
  // While disabled the target magnitude is already zero as seen by the ramp.
  assign tmag     = enable ? tgt_mag : '0;
  assign eff      = (tgt_dir == dir) ? tmag : '0;
  assign mismatch = (duty != tmag) || (dir != tgt_dir);

  always_comb begin
    stepped = duty;
    if (duty < eff)      stepped = ((eff - duty) <= STEP_V) ? eff : duty + STEP_V;
    else if (duty > eff) stepped = ((duty - eff) <= STEP_V) ? eff : duty - STEP_V;
  end

  always_comb begin
    state_n   = state;
    duty_n    = duty;
    dir_n     = dir;
    brake_n   = brake;
    cnt_n     = cnt;
    tgt_mag_n = tgt_mag;
    tgt_dir_n = tgt_dir;
    if (accept) begin
      tgt_mag_n = mag;
      tgt_dir_n = cmd_dir;
    end
    if (!enable) tgt_mag_n = '0;
    if (!run) begin
      state_n = IDLE;
      duty_n  = '0;
      brake_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mismatch) begin
            state_n = RAMP;
            if (adv) duty_n = stepped;
          end
        end
        RAMP: begin
          if (adv) begin
            if (!mismatch) begin
              state_n = IDLE;
            end else if (duty == '0 && dir != tgt_dir) begin
              state_n = DEAD;
              brake_n = 1'b1;
              cnt_n   = CW'(DEAD_TICKS);
            end else begin
              duty_n = stepped;
            end
          end
        end
        DEAD: begin
          if (tick) begin
            if (cnt <= CW'(1)) begin
              cnt_n   = '0;
              dir_n   = tgt_dir;
              brake_n = 1'b0;
              state_n = RAMP;
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      duty    <= '0;
      dir     <= 1'b0;
      brake   <= 1'b0;
      cnt     <= '0;
      tgt_mag <= '0;
      tgt_dir <= 1'b0;
    end else begin
      state   <= state_n;
      duty    <= duty_n;
      dir     <= dir_n;
      brake   <= brake_n;
      cnt     <= cnt_n;
      tgt_mag <= tgt_mag_n;
      tgt_dir <= tgt_dir_n;
    end
  end

  assign busy      = (state != IDLE);
  assign at_target = (duty == tgt_mag) && (dir == tgt_dir);

endmodule
